gen_sequencer: RTL and testbench

GEN_SEQUENCER -- requirements
Module: gen_sequencer

---
 rtl/gen_sequencer_pkg.sv | 31 +++
 rtl/gen_sequencer_if.sv | 24 ++
 rtl/gen_sequencer_row_counter.sv | 40 ++++
 rtl/gen_sequencer.sv | 153 +++++++++++++++
 tb/tb_gen_sequencer.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/gen_sequencer_pkg.sv
// Shared constants, state encoding and helpers for the Game-of-Life generation sequencer.
package gol_pkg;

   localparam int ROWS   = 8;
   localparam int ADDR_W = 3;
   localparam int GEN_W  = 8;
   localparam int FPG_W  = 6;
   localparam int LIM_W  = 7;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COPY    = 2'd1,
      COMPUTE = 2'd2,
      DISPLAY = 2'd3
   } state_e;

   localparam logic WSRC_DEC  = 1'b0;
   localparam logic WSRC_LOAD = 1'b1;

   localparam logic [ADDR_W-1:0] LAST_ROW = 3'd7;

   // A programmed value of zero stands for the largest frame count.
   function automatic logic [LIM_W-1:0] fpg_limit(input logic [FPG_W-1:0] fpg);
      if (fpg == 6'd0) begin
         return 7'd64;
      end else begin
         return {1'b0, fpg};
      end
   endfunction

endpackage

// File: rtl/gen_sequencer_if.sv
// Pattern-load handshake plus register-file / display control bundle.
interface gen_sequencer_if;
   import gol_pkg::*;

   logic              load_valid;
   logic [ADDR_W-1:0] load_addr;
   logic              load_ready;
   logic [ADDR_W-1:0] addr;
   logic              cur_we;
   logic              prev_we;
   logic              wsrc;
   logic              disp_en;

   modport master (
      input  load_valid, load_addr,
      output load_ready, addr, cur_we, prev_we, wsrc, disp_en
   );

   modport slave (
      output load_valid, load_addr,
      input  load_ready, addr, cur_we, prev_we, wsrc, disp_en
   );

endinterface

// File: rtl/gen_sequencer_row_counter.sv
// Wrapping row counter shared by the scan, copy, compute and display phases.
module row_counter
   import gol_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              en,
   output logic [ADDR_W-1:0] cnt,
   output logic              tc
);

   logic [ADDR_W-1:0] cnt_d;
   logic [ADDR_W-1:0] cnt_q;

   // Next row: clear has priority over advance.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = {ADDR_W{1'b0}};
      end else if (en) begin
         cnt_d = cnt_q + 3'd1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Row register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= {ADDR_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;
   assign tc  = (cnt_q == LAST_ROW);

endmodule

// File: rtl/gen_sequencer.sv
// Generation sequencer: scans/loads rows in IDLE, then copies, computes and displays one generation.
module gen_sequencer
   import gol_pkg::*;
(
   input  logic              ph1,
   input  logic              reset,
   input  logic              run,
   input  logic              step,
   input  logic [FPG_W-1:0]  frames_per_gen,
   gen_sequencer_if.master   bus,
   output logic [GEN_W-1:0]  gen_count,
   output logic              busy
);

   state_e             state_q, state_d;
   logic               active_q;
   logic               step_pend_q, step_pend_d;
   logic [LIM_W-1:0]   frame_cnt_q, frame_cnt_d;
   logic [LIM_W-1:0]   limit_q, limit_d;
   logic [GEN_W-1:0]   gen_q, gen_d;

   logic               row_clr_s;
   logic               row_en_s;
   logic               row_tc_s;
   logic [ADDR_W-1:0]  row_addr_s;

   logic [ADDR_W-1:0]  addr_s;
   logic               cur_we_s;
   logic               prev_we_s;
   logic               wsrc_s;
   logic               disp_en_s;
   logic               load_ready_s;
   logic               busy_s;

   row_counter u_row (
      .clk   (ph1),
      .rst_n (reset),
      .clr   (row_clr_s),
      .en    (row_en_s),
      .cnt   (row_addr_s),
      .tc    (row_tc_s)
   );

   // Next-state and output decode; nothing moves until the first edge after reset release.
   always_comb begin
      state_d      = state_q;
      step_pend_d  = step_pend_q;
      frame_cnt_d  = frame_cnt_q;
      limit_d      = limit_q;
      gen_d        = gen_q;
      row_clr_s    = 1'b0;
      row_en_s     = 1'b0;
      addr_s       = row_addr_s;
      cur_we_s     = 1'b0;
      prev_we_s    = 1'b0;
      wsrc_s       = WSRC_DEC;
      disp_en_s    = 1'b0;
      load_ready_s = 1'b0;
      busy_s       = 1'b0;
      if (!active_q) begin
         state_d = state_q;
      end else begin
         case (state_q)
            IDLE: begin
               load_ready_s = 1'b1;
               if (bus.load_valid) begin
                  addr_s      = bus.load_addr;
                  cur_we_s    = 1'b1;
                  wsrc_s      = WSRC_LOAD;
                  step_pend_d = step_pend_q | step;
               end else begin
                  disp_en_s = 1'b1;
                  if (run || step || step_pend_q) begin
                     state_d     = COPY;
                     row_clr_s   = 1'b1;
                     step_pend_d = 1'b0;
                  end else begin
                     row_en_s = 1'b1;
                  end
               end
            end
            COPY: begin
               busy_s    = 1'b1;
               prev_we_s = 1'b1;
               row_en_s  = 1'b1;
               if (row_tc_s) begin
                  state_d = COMPUTE;
               end else begin
                  state_d = COPY;
               end
            end
            COMPUTE: begin
               busy_s   = 1'b1;
               cur_we_s = 1'b1;
               row_en_s = 1'b1;
               if (row_tc_s) begin
                  state_d     = DISPLAY;
                  gen_d       = gen_q + 8'd1;
                  frame_cnt_d = 7'd0;
                  limit_d     = fpg_limit(frames_per_gen);
               end else begin
                  state_d = COMPUTE;
               end
            end
            DISPLAY: begin
               busy_s    = 1'b1;
               disp_en_s = 1'b1;
               row_en_s  = 1'b1;
               if (row_tc_s && (frame_cnt_q == limit_q - 7'd1)) begin
                  state_d = run ? COPY : IDLE;
               end else if (row_tc_s) begin
                  frame_cnt_d = frame_cnt_q + 7'd1;
               end else begin
                  state_d = DISPLAY;
               end
            end
            default: begin
               state_d   = IDLE;
               row_clr_s = 1'b1;
            end
         endcase
      end
   end

   // Sequencer state, counters and the post-reset enable.
   always_ff @(posedge ph1 or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         active_q    <= 1'b0;
         step_pend_q <= 1'b0;
         frame_cnt_q <= 7'd0;
         limit_q     <= 7'd64;
         gen_q       <= 8'd0;
      end else begin
         state_q     <= state_d;
         active_q    <= 1'b1;
         step_pend_q <= step_pend_d;
         frame_cnt_q <= frame_cnt_d;
         limit_q     <= limit_d;
         gen_q       <= gen_d;
      end
   end

   assign bus.addr       = addr_s;
   assign bus.cur_we     = cur_we_s;
   assign bus.prev_we    = prev_we_s;
   assign bus.wsrc       = wsrc_s;
   assign bus.disp_en    = disp_en_s;
   assign bus.load_ready = load_ready_s;
   assign busy           = busy_s;
   assign gen_count      = gen_q;

endmodule

// File: tb/tb_gen_sequencer.sv
// Scoreboard bench: a cycle-level phase model predicts every output cycle; a negedge monitor compares.
module tb_gen_sequencer;
   import gol_pkg::*;

   logic       ph1   = 1'b0;
   logic       reset = 1'b0;
   logic       run   = 1'b0;
   logic       step  = 1'b0;
   logic [5:0] fpg   = 6'd0;
   logic [7:0] gen_count;
   logic       busy;

   gen_sequencer_if bus();

   gen_sequencer dut (
      .ph1            (ph1),
      .reset          (reset),
      .run            (run),
      .step           (step),
      .frames_per_gen (fpg),
      .bus            (bus),
      .gen_count      (gen_count),
      .busy           (busy)
   );

   always #5 ph1 = ~ph1;

   typedef struct packed {
      logic [2:0] addr;
      logic       cur_we;
      logic       prev_we;
      logic       wsrc;
      logic       disp_en;
      logic       load_ready;
      logic       busy;
      logic [7:0] gen;
   } obs_t;

   obs_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   // Model: mode 0 idle, 1 copy, 2 compute, 3 display; m_pos counts cycles within the phase.
   int   m_mode = 0, m_pos = 0, m_scan = 0, m_lim = 64, m_gen = 0;
   bit   m_act = 0, m_pend = 0;

   task automatic drive(input bit r, input bit rn, input bit st, input bit lv,
                        input logic [2:0] la, input logic [5:0] f);
      obs_t e;
      @(posedge ph1);
      #1;
      reset = rn; run = r; step = st; fpg = f;
      bus.load_valid = lv; bus.load_addr = la;
      e = '0;
      if (!rn) begin
         m_act = 0; m_mode = 0; m_pos = 0; m_scan = 0; m_gen = 0; m_pend = 0;
      end else if (!m_act) begin
         m_act = 1;
      end else begin
         e.gen = 8'(m_gen);
         case (m_mode)
            0: begin
               e.load_ready = 1'b1;
               if (lv) begin
                  e.addr = la; e.cur_we = 1'b1; e.wsrc = 1'b1;
                  if (st) m_pend = 1;
               end else begin
                  e.addr = 3'(m_scan); e.disp_en = 1'b1;
                  if (r || st || m_pend) begin
                     m_mode = 1; m_pos = 0; m_pend = 0; m_scan = 0;
                  end else begin
                     m_scan = (m_scan + 1) % 8;
                  end
               end
            end
            1: begin
               e.addr = 3'(m_pos); e.prev_we = 1'b1; e.busy = 1'b1;
               m_pos++;
               if (m_pos == 8) begin m_mode = 2; m_pos = 0; end
            end
            2: begin
               e.addr = 3'(m_pos); e.cur_we = 1'b1; e.busy = 1'b1;
               m_pos++;
               if (m_pos == 8) begin
                  m_gen = (m_gen + 1) % 256;
                  m_lim = (f == 6'd0) ? 64 : int'(f);
                  m_mode = 3; m_pos = 0;
               end
            end
            3: begin
               e.addr = 3'(m_pos % 8); e.disp_en = 1'b1; e.busy = 1'b1;
               m_pos++;
               if (m_pos == 8 * m_lim) begin
                  m_mode = r ? 1 : 0; m_pos = 0; m_scan = 0;
               end
            end
            default: ;
         endcase
      end
      exp_q.push_back(e);
   endtask

   obs_t mon_a, mon_e;

   // Monitor: one full-output comparison plus the write-enable exclusivity check per cycle.
   always @(negedge ph1) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         mon_a = {bus.addr, bus.cur_we, bus.prev_we, bus.wsrc, bus.disp_en,
                  bus.load_ready, busy, gen_count};
         cyc++;
         checks++;
         if (mon_a !== mon_e) begin
            failures++;
            $display("FAIL outputs cyc=%0d actual addr=%0d cur=%b prev=%b wsrc=%b disp=%b lr=%b busy=%b gen=%0d required addr=%0d cur=%b prev=%b wsrc=%b disp=%b lr=%b busy=%b gen=%0d",
                     cyc, mon_a.addr, mon_a.cur_we, mon_a.prev_we, mon_a.wsrc, mon_a.disp_en,
                     mon_a.load_ready, mon_a.busy, mon_a.gen,
                     mon_e.addr, mon_e.cur_we, mon_e.prev_we, mon_e.wsrc, mon_e.disp_en,
                     mon_e.load_ready, mon_e.busy, mon_e.gen);
         end
         checks++;
         if ((bus.cur_we & bus.prev_we) !== 1'b0) begin
            failures++;
            $display("FAIL we_exclusive cyc=%0d actual cur&prev=%b required 0", cyc, bus.cur_we & bus.prev_we);
         end
      end
   end

   initial begin
      bus.load_valid = 1'b0;
      bus.load_addr  = 3'd0;
      repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 6'd0);

      // Continuous run, two frames per generation.
      repeat (70) drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 6'd2);
      repeat (40) drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 6'd2);

      // Single step with the 64-frame limit; later fpg changes must not alter it.
      drive(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 6'd0);
      repeat (20) drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 6'd0);
      repeat (540) drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 6'($urandom_range(63)));

      // Load wins over run, then the generation starts.
      repeat (2) drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd5, 6'd2);
      repeat (6) drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 6'd2);
      repeat (40) drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 6'd2);

      // Drop run on display cycle 3, with loads and steps offered during display.
      for (int i = 0; i < 200 && !(m_mode == 3 && m_pos == 2); i++)
         drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 6'd3);
      repeat (22) drive(1'b0, 1'b1, 1'($urandom_range(1)), 1'b1, 3'($urandom_range(7)), 6'd3);
      repeat (20) drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 6'd3);

      // Reset during compute cycle 4.
      for (int i = 0; i < 200 && !(m_mode == 2 && m_pos == 3); i++)
         drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 6'd2);
      repeat (2) drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 6'd2);
      repeat (10) drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 6'd2);

      // 256 one-frame generations so gen_count wraps.
      for (int i = 0; i < 7000 && m_gen != 255; i++)
         drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 6'd1);
      for (int i = 0; i < 100 && m_gen != 0; i++)
         drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 6'd1);
      repeat (40) drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 6'd1);

      // Random traffic including occasional resets.
      for (int i = 0; i < 3000; i++)
         drive(1'($urandom_range(9) < 7), 1'($urandom_range(499) != 0),
               1'($urandom_range(19) == 0), 1'($urandom_range(3) == 0),
               3'($urandom_range(7)), 6'($urandom_range(4)));
      repeat (5) drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 6'd1);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge ph1);
      #2;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
